tpu_mac_lanes: RTL and testbench

Multi-lane, two-stage pipelined multiply-accumulate engine for the TPU datapath. It is the successor to the single-lane simple MAC and adds:
- `LANES` parallel lanes, parametrised widths and signed/unsigned element types;
- a persistent per-lane accumulator mode;
- valid/ready handshakes with full output backpressure.

It sits between the operand fetch/staging logic and the result writeback buffer.

---
 rtl/tpu_mac_lanes.sv | 160 ++++++++++++++++
 tb/tb_tpu_mac_lanes.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_mac_lanes.sv
// tpu_mac_lanes: LANES-wide, two-stage pipelined multiply-accumulate engine.
// S1 registers the per-lane product plus sidebands. S2 registers the add/accumulate
// result. A single advance signal moves both stages, so a stalled output freezes the
// whole pipe. Optional saturation of the S2 adder is enabled by defining TPU_MAC_SAT_EN.
module tpu_mac_lanes #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [2:0]                 data_type_i,
    input  logic                       acc_mode_i,
    input  logic                       acc_clear_i,
    input  logic [LANES*IN_WIDTH-1:0]  a_data_i,
    input  logic [LANES*IN_WIDTH-1:0]  b_data_i,
    input  logic [LANES*ACC_WIDTH-1:0] c_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [LANES*ACC_WIDTH-1:0] result_o,
    output logic [LANES-1:0]           sat_flag_o,
    output logic                       busy_o
);

    logic                 adv;

    // Operands extended to ACC_WIDTH; the low ACC_WIDTH bits of their product are exact
    // because ACC_WIDTH >= 2*IN_WIDTH.
    logic [ACC_WIDTH-1:0] a_ext    [LANES];
    logic [ACC_WIDTH-1:0] b_ext    [LANES];
    logic [ACC_WIDTH-1:0] s1_prod_d[LANES];

    logic                 s1_valid_q;
    logic                 s1_mode_q;
    logic                 s1_clear_q;
    logic [ACC_WIDTH-1:0] s1_prod_q[LANES];
    logic [ACC_WIDTH-1:0] s1_c_q   [LANES];

    logic [ACC_WIDTH-1:0] base     [LANES];
    logic [ACC_WIDTH-1:0] sum_d    [LANES];
    logic [LANES-1:0]     sat_d;

    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] res_q    [LANES];
    logic [ACC_WIDTH-1:0] acc_q    [LANES];
    logic [LANES-1:0]     sat_q;

    assign adv         = !out_valid_q || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = out_valid_q;
    assign sat_flag_o  = sat_q;
    assign busy_o      = s1_valid_q || out_valid_q;

    // Operand extension by element type, then per-lane multiply.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_ext[i] = '0;
            b_ext[i] = '0;
            case (data_type_i)
                3'b000: begin
                    a_ext[i] = {{(ACC_WIDTH-8){a_data_i[i*IN_WIDTH+7]}}, a_data_i[i*IN_WIDTH +: 8]};
                    b_ext[i] = {{(ACC_WIDTH-8){b_data_i[i*IN_WIDTH+7]}}, b_data_i[i*IN_WIDTH +: 8]};
                end
                3'b010: begin
                    a_ext[i] = {{(ACC_WIDTH-8){1'b0}}, a_data_i[i*IN_WIDTH +: 8]};
                    b_ext[i] = {{(ACC_WIDTH-8){1'b0}}, b_data_i[i*IN_WIDTH +: 8]};
                end
                default: begin
                    a_ext[i] = {{(ACC_WIDTH-IN_WIDTH){a_data_i[i*IN_WIDTH+IN_WIDTH-1]}},
                                a_data_i[i*IN_WIDTH +: IN_WIDTH]};
                    b_ext[i] = {{(ACC_WIDTH-IN_WIDTH){b_data_i[i*IN_WIDTH+IN_WIDTH-1]}},
                                b_data_i[i*IN_WIDTH +: IN_WIDTH]};
                end
            endcase
            s1_prod_d[i] = a_ext[i] * b_ext[i];
        end
    end

    // S2 adder: addend is c, the live accumulator, or zero on a clearing accumulate beat.
    always_comb begin
        sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            base[i] = s1_mode_q ? (s1_clear_q ? '0 : acc_q[i]) : s1_c_q[i];
`ifdef TPU_MAC_SAT_EN
            begin
                logic [ACC_WIDTH:0] sum_ext;
                sum_ext  = {base[i][ACC_WIDTH-1], base[i]}
                         + {s1_prod_q[i][ACC_WIDTH-1], s1_prod_q[i]};
                sum_d[i] = sum_ext[ACC_WIDTH-1:0];
                // Top two bits disagree only on signed overflow; clamp toward the true sign.
                if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
                    sat_d[i] = 1'b1;
                    sum_d[i] = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end
`else
            sum_d[i] = base[i] + s1_prod_q[i];
`endif
        end
    end

    // S1 register: product and sidebands, loaded on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_clear_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
                s1_c_q[i]    <= '0;
            end
        end else if (adv) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_mode_q  <= acc_mode_i;
                s1_clear_q <= acc_clear_i;
                for (int i = 0; i < LANES; i++) begin
                    s1_prod_q[i] <= s1_prod_d[i];
                    s1_c_q[i]    <= c_data_i[i*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    // S2 register and accumulators; the accumulator commits on the S1->S2 transfer so the
    // next beat, now in S1, already sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sat_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                res_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sat_q <= sat_d;
                for (int i = 0; i < LANES; i++) begin
                    res_q[i] <= sum_d[i];
                    if (s1_mode_q) begin
                        acc_q[i] <= sum_d[i];
                    end
                end
            end
        end
    end

    // Pack per-lane results onto the output bus.
    always_comb begin
        result_o = '0;
        for (int i = 0; i < LANES; i++) begin
            result_o[i*ACC_WIDTH +: ACC_WIDTH] = res_q[i];
        end
    end

endmodule

// File: tb/tb_tpu_mac_lanes.sv
// Scoreboard bench for tpu_mac_lanes (LANES=4, IN_WIDTH=16, ACC_WIDTH=32).
// The driver pushes the hand-computed response of each accepted beat; the monitor pops
// and compares on every output transfer and checks stall stability.
module tb_tpu_mac_lanes;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   data_type;
    logic         acc_mode;
    logic         acc_clear;
    logic [63:0]  a_data;
    logic [63:0]  b_data;
    logic [127:0] c_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic [3:0]   sat_flag;
    logic         busy;

    typedef struct {
        string        name;
        logic [127:0] exp;
        logic [3:0]   sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_end = 0;

    tpu_mac_lanes #(
        .LANES    (4),
        .IN_WIDTH (16),
        .ACC_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .data_type_i(data_type),
        .acc_mode_i (acc_mode),
        .acc_clear_i(acc_clear),
        .a_data_i   (a_data),
        .b_data_i   (b_data),
        .c_data_i   (c_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .sat_flag_o (sat_flag),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream readiness: low while cyc < stall_end.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = (cyc >= stall_end);
        end
    end

    function automatic logic [63:0] p16(logic [15:0] l0, logic [15:0] l1,
                                        logic [15:0] l2, logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] p32(logic [31:0] l0, logic [31:0] l1,
                                         logic [31:0] l2, logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one beat from a negedge until accepted; push its expectation if asked.
    task automatic send(string name, logic [2:0] dt, logic mode, logic clr, logic [63:0] a,
                        logic [63:0] b, logic [127:0] c, logic [127:0] exp,
                        logic [3:0] sat, bit push);
        exp_t e;
        bit   done = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            data_type = dt;
            acc_mode  = mode;
            acc_clear = clr;
            a_data    = a;
            b_data    = b;
            c_data    = c;
            #1;
            if (in_ready) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout %s: in_ready got 0, expected 1", name);
        end else if (push) begin
            e.name = name;
            e.exp  = exp;
            e.sat  = sat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 60) begin
            @(negedge clk);
            in_valid = 1'b0;
            t++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare on each output transfer; check stall behaviour.
    initial begin
        exp_t         e;
        bit           prev_stall = 0;
        logic [127:0] held_res;
        logic [3:0]   held_sat;
        forever begin
            @(negedge clk);
            #1;
            if (prev_stall && rst_n) begin
                check("stall_valid_held", {127'd0, out_valid}, 128'd1);
                check("stall_result_held", result, held_res);
                check("stall_sat_held", {124'd0, sat_flag}, {124'd0, held_sat});
            end
            if (rst_n && out_valid && !out_ready) begin
                check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            end
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no output", result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.exp);
                    check({e.name, "_sat"}, {124'd0, sat_flag}, {124'd0, e.sat});
                end
            end
            prev_stall = rst_n && out_valid && !out_ready;
            held_res   = result;
            held_sat   = sat_flag;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] ex;
        logic [127:0] ex_sat;
        logic [3:0]   sat_req;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_type = 3'b001;
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        a_data    = '0;
        b_data    = '0;
        c_data    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_result", result, 128'd0);
        check("rst_sat", {124'd0, sat_flag}, 128'd0);

        // Latency: beat presented in cycle k, out_valid seen in cycle k+2.
        send("int16_basic", 3'b001, 1'b0, 1'b0,
             p16(16'd3, 16'hFFFB, 16'd10, 16'hFFFF), p16(16'hFFFC, 16'hFFFA, 16'd10, 16'd1),
             p32(32'd100, 32'hFFFF_FFFF, 32'd0, 32'd0),
             p32(32'd88, 32'd29, 32'd100, 32'hFFFF_FFFF), 4'b0, 1);
        idle();
        #1;
        check("lat_not_yet", {127'd0, out_valid}, 128'd0);
        @(negedge clk);
        #1;
        check("lat_two_cycles", {127'd0, out_valid}, 128'd1);
        drain();

        // Element types; INT8 ignores the upper byte, "other" codes behave as INT16.
        send("int8", 3'b000, 1'b0, 1'b0,
             p16(16'h00FF, 16'hABFF, 16'h0080, 16'h0007), p16(16'h0002, 16'h0002, 16'h0001, 16'h00F9),
             '0, p32(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FF80, 32'hFFFF_FFCF), 4'b0, 1);
        send("uint8", 3'b010, 1'b0, 1'b0,
             p16(16'h00FF, 16'hABFF, 16'h0080, 16'h0007), p16(16'h0002, 16'h0002, 16'h0001, 16'h00F9),
             '0, p32(32'h0000_01FE, 32'h0000_01FE, 32'h0000_0080, 32'h0000_06CF), 4'b0, 1);
        send("dt_other", 3'b101, 1'b0, 1'b0,
             p16(16'h00FF, 16'hFFFF, 16'h8000, 16'h8000), p16(16'h0002, 16'h0002, 16'h0001, 16'h8000),
             '0, p32(32'h0000_01FE, 32'hFFFF_FFFE, 32'hFFFF_8000, 32'h4000_0000), 4'b0, 1);
        drain();

        // Back-to-back accumulation, an interleaved plain beat, then accumulation resumes.
        for (int k = 1; k <= 4; k++) begin
            send("acc", 3'b001, 1'b1, (k == 1),
                 p16(16'd2, 16'd3, 16'd1, 16'hFFFE), p16(16'd2, 16'hFFFF, 16'd1, 16'hFFFE), '0,
                 p32(32'(4 * k), 32'(-3 * k), 32'(k), 32'(4 * k)), 4'b0, 1);
        end
        send("mixed_plain", 3'b001, 1'b0, 1'b0,
             p16(16'd2, 16'd3, 16'd1, 16'hFFFE), p16(16'd2, 16'hFFFF, 16'd1, 16'hFFFE),
             p32(32'd1, 32'd1, 32'd1, 32'd1), p32(32'd5, 32'hFFFF_FFFE, 32'd2, 32'd5), 4'b0, 1);
        send("acc_resume", 3'b001, 1'b1, 1'b0,
             p16(16'd2, 16'd3, 16'd1, 16'hFFFE), p16(16'd2, 16'hFFFF, 16'd1, 16'hFFFE), '0,
             p32(32'd20, 32'hFFFF_FFF1, 32'd5, 32'd20), 4'b0, 1);
        drain();

        // Backpressure: 3-cycle downstream stall in the middle of a 6-beat stream.
        for (int k = 0; k < 6; k++) begin
            if (k == 2) stall_end = cyc + 3;
            ex = '0;
            for (int l = 0; l < 4; l++) begin
                ex[l*32 +: 32] = 32'((k + 1) * (l + 2) + 16 * k);
            end
            send("bp", 3'b001, 1'b0, 1'b0,
                 p16(16'(k + 1), 16'(k + 1), 16'(k + 1), 16'(k + 1)),
                 p16(16'd2, 16'd3, 16'd4, 16'd5),
                 p32(32'(16 * k), 32'(16 * k), 32'(16 * k), 32'(16 * k)), ex, 4'b0, 1);
        end
        drain();

        // Saturation boundary: positive overflow, negative overflow, exact max, zero.
`ifdef TPU_MAC_SAT_EN
        ex_sat  = p32(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
        sat_req = 4'b0011;
`else
        ex_sat  = p32(32'hBFFE_0001, 32'h4000_8000, 32'h7FFF_FFFF, 32'd0);
        sat_req = 4'b0000;
`endif
        send("sat", 3'b001, 1'b0, 1'b0,
             p16(16'h7FFF, 16'h8000, 16'd1, 16'd0), p16(16'h7FFF, 16'h7FFF, 16'd1, 16'd0),
             p32(32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_FFFE, 32'd0), ex_sat, sat_req, 1);
        drain();

        // Reset with two beats in flight after loading the accumulators with 9.
        send("acc_pre_rst", 3'b001, 1'b1, 1'b1, p16(16'd3, 16'd3, 16'd3, 16'd3),
             p16(16'd3, 16'd3, 16'd3, 16'd3), '0, p32(32'd9, 32'd9, 32'd9, 32'd9), 4'b0, 1);
        drain();
        stall_end = cyc + 1000;
        for (int k = 0; k < 2; k++) begin
            send("inflight", 3'b001, 1'b1, 1'b0, p16(16'd1, 16'd1, 16'd1, 16'd1),
                 p16(16'd1, 16'd1, 16'd1, 16'd1), '0, '0, 4'b0, 0);
        end
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        stall_end = 0;
        send("acc_after_rst", 3'b001, 1'b1, 1'b0, p16(16'd1, 16'd1, 16'd1, 16'd1),
             p16(16'd1, 16'd1, 16'd1, 16'd1), '0, p32(32'd1, 32'd1, 32'd1, 32'd1), 4'b0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
